jtsdram_bank_check: RTL and testbench

- Parametrised SDRAM bank self-test engine; successor to the single-mode read-verify bank checker.
- Sweeps one bank's full address range through the SDRAM controller's request/ack/rdy port.
- Optional write pass precedes a read-verify pass. Pattern is selectable: constant, address-derived, or address-derived inverted.
- Reports pass/fail, saturating error count, first failing address and request timeout to the test-top status logic.

---
 rtl/jtsdram_bank_check_if.sv | 26 ++
 rtl/jtsdram_bank_check.sv | 201 ++++++++++++++++++++
 tb/tb_jtsdram_bank_check.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtsdram_bank_check_if.sv
// Request/ack/rdy port between the bank self-test engine and the SDRAM controller.
// The engine is the master: it owns the address, request strobes and write data.
interface jtsdram_bank_check_if #(
  parameter int AW = 22,
  parameter int DW = 16
);
  localparam int RW = 2 * DW;

  logic [AW-1:0] addr;
  logic          rd;
  logic          wr;
  logic [RW-1:0] data_write;
  logic          ack;
  logic          rdy;
  logic [RW-1:0] data_read;

  modport master (
    output addr, rd, wr, data_write,
    input  ack, rdy, data_read
  );

  modport slave (
    input  addr, rd, wr, data_write,
    output ack, rdy, data_read
  );
endinterface

// File: rtl/jtsdram_bank_check.sv
// SDRAM bank self-test: optional write sweep, then a read-verify sweep of the whole bank.
// Status (bad/timeout/err_cnt/fail_addr/done) is held after the sweep until the next start.
//
// state  | meaning
// IDLE   | after reset, nothing requested
// WREQ   | write request asserted, waiting for ack
// WWAIT  | write accepted, waiting for rdy (write complete)
// RREQ   | read request asserted, waiting for ack
// RWAIT  | read accepted, waiting for rdy (data valid)
// DONE   | sweep finished or aborted by timeout, status held
module jtsdram_bank_check #(
  parameter int AW   = 22,
  parameter int DW   = 16,
  parameter int ECW  = 8,
  parameter int TOUT = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [1:0]                  mode_i,
  input  logic [DW-1:0]               data_ref_i,
  jtsdram_bank_check_if.master        sd,
  output logic                        busy_o,
  output logic                        bad_o,
  output logic                        timeout_o,
  output logic [ECW-1:0]              err_cnt_o,
  output logic [AW-1:0]               fail_addr_o,
  output logic                        done_o
);

  localparam int RW = 2 * DW;
  localparam int CW = (TOUT > 1) ? $clog2(TOUT) : 1;
  localparam logic [CW-1:0] TLIM = CW'((TOUT > 0) ? TOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREQ,
    S_WWAIT,
    S_RREQ,
    S_RWAIT,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [1:0]      mode_q;
  logic [AW-1:0]   addr_q;
  logic            rd_q;
  logic            wr_q;
  logic            busy_q;
  logic            bad_q;
  logic            timeout_q;
  logic            done_q;
  logic [ECW-1:0]  err_cnt_q;
  logic [AW-1:0]   fail_addr_q;
  logic [CW-1:0]   cnt_q;

  logic [RW-1:0]   base;
  logic [RW-1:0]   pattern;
  logic            addr_last;
  logic            mismatch;
  logic            waiting;
  logic            exit_ev;
  logic            tout_hit;

  // Expected word for the current address; address is zero-extended or truncated to RW.
  always_comb begin
    base = {2{data_ref_i}};
    case (mode_q)
      2'd2:    pattern = base ^ RW'(addr_q);
      2'd3:    pattern = ~(base ^ RW'(addr_q));
      default: pattern = base;
    endcase
  end

  assign addr_last = &addr_q;
  assign mismatch  = (sd.data_read != pattern);
  assign tout_hit  = (TOUT > 0) && (cnt_q == TLIM);

  // Only ack leaves a request state and only rdy leaves a wait state.
  always_comb begin
    waiting = 1'b0;
    exit_ev = 1'b0;
    case (state_q)
      S_WREQ, S_RREQ: begin
        waiting = 1'b1;
        exit_ev = sd.ack;
      end
      S_WWAIT, S_RWAIT: begin
        waiting = 1'b1;
        exit_ev = sd.rdy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      bad_q       <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      cnt_q       <= '0;
    end else if (start_i) begin
      mode_q      <= mode_i;
      addr_q      <= '0;
      bad_q       <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      busy_q      <= 1'b1;
      cnt_q       <= '0;
      if (mode_i == 2'd0) begin
        state_q <= S_RREQ;
        rd_q    <= 1'b1;
        wr_q    <= 1'b0;
      end else begin
        state_q <= S_WREQ;
        wr_q    <= 1'b1;
        rd_q    <= 1'b0;
      end
    end else if (waiting && !exit_ev) begin
      if (tout_hit) begin
        timeout_q <= 1'b1;
        bad_q     <= 1'b1;
        rd_q      <= 1'b0;
        wr_q      <= 1'b0;
        done_q    <= 1'b1;
        busy_q    <= 1'b0;
        cnt_q     <= '0;
        state_q   <= S_DONE;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
      case (state_q)
        S_WREQ: begin
          wr_q    <= 1'b0;
          state_q <= S_WWAIT;
        end
        S_WWAIT: begin
          if (addr_last) begin
            addr_q  <= '0;
            rd_q    <= 1'b1;
            state_q <= S_RREQ;
          end else begin
            addr_q  <= addr_q + 1'b1;
            wr_q    <= 1'b1;
            state_q <= S_WREQ;
          end
        end
        S_RREQ: begin
          rd_q    <= 1'b0;
          state_q <= S_RWAIT;
        end
        S_RWAIT: begin
          if (mismatch) begin
            bad_q <= 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_q <= err_cnt_q + 1'b1;
            end
            if (err_cnt_q == '0) begin
              fail_addr_q <= addr_q;
            end
          end
          if (addr_last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            addr_q  <= addr_q + 1'b1;
            rd_q    <= 1'b1;
            state_q <= S_RREQ;
          end
        end
        default: ;
      endcase
    end
  end

  assign sd.addr       = addr_q;
  assign sd.rd         = rd_q;
  assign sd.wr         = wr_q;
  assign sd.data_write = wr_q ? pattern : '0;

  assign busy_o      = busy_q;
  assign bad_o       = bad_q;
  assign timeout_o   = timeout_q;
  assign err_cnt_o   = err_cnt_q;
  assign fail_addr_o = fail_addr_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_jtsdram_bank_check.sv
// Bench for jtsdram_bank_check: SDRAM controller responder with memory plus a sweep-level model.
// Small bank (AW=4), 2-bit error counter and 8-cycle timeout so all boundaries are reachable.
module tb_jtsdram_bank_check;

  localparam int AW   = 4;
  localparam int DW   = 16;
  localparam int ECW  = 2;
  localparam int TOUT = 8;
  localparam int RW   = 32;
  localparam int N    = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_i = 1'b0;
  logic [1:0]     mode_i = 2'd0;
  logic [DW-1:0]  data_ref_i = '0;
  logic           busy_o, bad_o, timeout_o, done_o;
  logic [ECW-1:0] err_cnt_o;
  logic [AW-1:0]  fail_addr_o;

  jtsdram_bank_check_if #(.AW(AW), .DW(DW)) sd_if ();

  jtsdram_bank_check #(.AW(AW), .DW(DW), .ECW(ECW), .TOUT(TOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .data_ref_i  (data_ref_i),
    .sd          (sd_if),
    .busy_o      (busy_o),
    .bad_o       (bad_o),
    .timeout_o   (timeout_o),
    .err_cnt_o   (err_cnt_o),
    .fail_addr_o (fail_addr_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Responder state and knobs
  logic [RW-1:0] mem     [N];
  logic [RW-1:0] corrupt [N];
  bit            resp_en = 1'b0;
  bit            rand_dly = 1'b0;
  int            ack_dly_fix = 1;
  int            rdy_dly_fix = 1;
  bit            hang_en = 1'b0;
  int            hang_addr = 0;
  int            hang_cycles = 0;
  int            both_cnt = 0;
  int            wr_cycles = 0;
  int            wr_a [$];
  logic [RW-1:0] wr_d [$];
  int            rd_a [$];

  logic          resp_ack = 1'b0, resp_rdy = 1'b0;
  logic [RW-1:0] resp_data = '0;
  bit            ovr_en = 1'b0;
  logic          ovr_ack = 1'b0, ovr_rdy = 1'b0;

  assign sd_if.ack       = ovr_en ? ovr_ack : resp_ack;
  assign sd_if.rdy       = ovr_en ? ovr_rdy : resp_rdy;
  assign sd_if.data_read = resp_data;

  // Controller model: one outstanding access, ack some cycles after the request, rdy later.
  initial begin
    int phase;
    int cnt;
    int a;
    bit isw;
    phase = 0; cnt = 0; a = 0; isw = 1'b0;
    forever begin
      @(negedge clk);
      if (sd_if.rd && sd_if.wr) both_cnt++;
      if (sd_if.wr) wr_cycles++;
      resp_ack  = 1'b0;
      resp_rdy  = 1'b0;
      resp_data = $urandom;
      if (!resp_en) begin
        phase = 0;
      end else if (phase == 0) begin
        if (sd_if.rd || sd_if.wr) begin
          if (hang_en && sd_if.rd && int'(sd_if.addr) == hang_addr) begin
            hang_cycles++;
          end else begin
            a   = int'(sd_if.addr);
            isw = sd_if.wr;
            if (isw) begin
              mem[a] = sd_if.data_write;
              wr_a.push_back(a);
              wr_d.push_back(sd_if.data_write);
            end else begin
              rd_a.push_back(a);
            end
            cnt = rand_dly ? int'($urandom_range(0, 3)) : ack_dly_fix;
            if (cnt == 0) begin
              resp_ack = 1'b1;
              phase    = 2;
              cnt      = rand_dly ? int'($urandom_range(1, 4)) : rdy_dly_fix;
            end else begin
              phase = 1;
            end
          end
        end
      end else if (phase == 1) begin
        cnt--;
        if (cnt == 0) begin
          resp_ack = 1'b1;
          phase    = 2;
          cnt      = rand_dly ? int'($urandom_range(1, 4)) : rdy_dly_fix;
        end
      end else begin
        cnt--;
        if (cnt == 0) begin
          resp_rdy = 1'b1;
          if (!isw) resp_data = mem[a] ^ corrupt[a];
          phase = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] pat(input logic [1:0] m, input logic [DW-1:0] d, input int a);
    logic [RW-1:0] b;
    b = {d, d};
    case (m)
      2'd2:    return b ^ RW'(a);
      2'd3:    return ~(b ^ RW'(a));
      default: return b;
    endcase
  endfunction

  task automatic clear_logs();
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
    hang_cycles = 0;
    both_cnt    = 0;
    wr_cycles   = 0;
  endtask

  task automatic prep(input logic [1:0] m, input logic [DW-1:0] d);
    for (int a = 0; a < N; a++) mem[a] = pat(m, d, a);
  endtask

  task automatic start_sweep(input logic [1:0] m, input logic [DW-1:0] d);
    clear_logs();
    mode_i     = m;
    data_ref_i = d;
    start_i    = 1'b1;
    step();
    start_i    = 1'b0;
  endtask

  task automatic wait_done(input string tg, input int budget);
    int k;
    k = 0;
    while (!done_o && k < budget) begin
      step();
      k++;
    end
    chk({tg, ".done_in_time"}, done_o, 1'b1);
  endtask

  // Whole-sweep expectations from the stored contents and the injected read corruption.
  task automatic check_sweep(input string tg, input logic [1:0] m, input logic [DW-1:0] d);
    int nerr;
    int first;
    int nwr;
    logic [RW-1:0] got;
    nerr = 0; first = 0;
    for (int a = 0; a < N; a++) begin
      got = ((m != 2'd0) ? pat(m, d, a) : mem[a]) ^ corrupt[a];
      if (got != pat(m, d, a)) begin
        if (nerr == 0) first = a;
        nerr++;
      end
    end
    nwr = (m != 2'd0) ? N : 0;
    chk({tg, ".done"},      done_o, 1'b1);
    chk({tg, ".busy"},      busy_o, 1'b0);
    chk({tg, ".timeout"},   timeout_o, 1'b0);
    chk({tg, ".bad"},       bad_o, (nerr > 0));
    chk({tg, ".err_cnt"},   err_cnt_o, (nerr > 3) ? 3 : nerr);
    chk({tg, ".fail_addr"}, fail_addr_o, first);
    chk({tg, ".addr_end"},  sd_if.addr, N - 1);
    chk({tg, ".rd_idle"},   sd_if.rd, 1'b0);
    chk({tg, ".wr_idle"},   sd_if.wr, 1'b0);
    chk({tg, ".rd_and_wr"}, both_cnt, 0);
    chk({tg, ".n_writes"},  wr_a.size(), nwr);
    for (int i = 0; i < wr_a.size() && i < N; i++) begin
      chk($sformatf("%s.wr_addr[%0d]", tg, i), wr_a[i], i);
      chk($sformatf("%s.wr_data[%0d]", tg, i), wr_d[i], pat(m, d, i));
    end
    chk({tg, ".n_reads"},   rd_a.size(), N);
    for (int i = 0; i < rd_a.size() && i < N; i++) begin
      chk($sformatf("%s.rd_addr[%0d]", tg, i), rd_a[i], i);
    end
    if (m == 2'd0) chk({tg, ".no_wr_cycles"}, wr_cycles, 0);
  endtask

  initial begin
    logic [1:0]    m;
    logic [DW-1:0] d;
    int k;

    for (int a = 0; a < N; a++) begin
      mem[a]     = '0;
      corrupt[a] = '0;
    end

    // Reset values
    #2;
    chk("rst.busy",       busy_o, 1'b0);
    chk("rst.bad",        bad_o, 1'b0);
    chk("rst.timeout",    timeout_o, 1'b0);
    chk("rst.done",       done_o, 1'b0);
    chk("rst.err_cnt",    err_cnt_o, 0);
    chk("rst.fail_addr",  fail_addr_o, 0);
    chk("rst.rd_wr",      {sd_if.rd, sd_if.wr}, 2'b00);
    chk("rst.addr",       sd_if.addr, 0);
    chk("rst.data_write", sd_if.data_write, 0);
    step();
    step();
    rst_n   = 1'b1;
    resp_en = 1'b1;
    step();
    chk("idle.busy", busy_o, 1'b0);

    // 1: read-verify constant, ack after 2, rdy 3 later
    rand_dly = 1'b0; ack_dly_fix = 2; rdy_dly_fix = 3;
    prep(2'd0, 16'hA55A);
    start_sweep(2'd0, 16'hA55A);
    chk("t1.busy_after_start", busy_o, 1'b1);
    chk("t1.first_req", {sd_if.rd, sd_if.wr, sd_if.addr}, {2'b10, 4'd0});
    wait_done("t1", 600);
    check_sweep("t1", 2'd0, 16'hA55A);
    step(); step(); step();
    chk("t1.done_held", done_o, 1'b1);

    // 2: write+verify address pattern
    ack_dly_fix = 1; rdy_dly_fix = 2;
    start_sweep(2'd2, 16'h1234);
    wait_done("t2", 600);
    check_sweep("t2", 2'd2, 16'h1234);

    // 3: bit 0 flipped on reads of 5 and 9
    corrupt[5] = 32'h1;
    corrupt[9] = 32'h1;
    start_sweep(2'd2, 16'h1234);
    wait_done("t3", 600);
    check_sweep("t3", 2'd2, 16'h1234);
    chk("t3.err_cnt_2", err_cnt_o, 2);
    chk("t3.fail_addr_5", fail_addr_o, 5);
    for (int a = 0; a < N; a++) corrupt[a] = '0;

    // 4: every read wrong, counter saturates
    d = $urandom;
    prep(2'd0, d);
    for (int a = 0; a < N; a++) corrupt[a] = RW'($urandom) | 32'h0001_0000;
    start_sweep(2'd0, d);
    wait_done("t4", 600);
    check_sweep("t4", 2'd0, d);
    chk("t4.err_sat", err_cnt_o, 3);
    for (int a = 0; a < N; a++) corrupt[a] = '0;

    // 5: controller never acks the read of address 2
    d = $urandom;
    prep(2'd0, d);
    hang_en = 1'b1; hang_addr = 2;
    start_sweep(2'd0, d);
    wait_done("t5", 200);
    chk("t5.timeout",     timeout_o, 1'b1);
    chk("t5.bad",         bad_o, 1'b1);
    chk("t5.busy",        busy_o, 1'b0);
    chk("t5.rd",          sd_if.rd, 1'b0);
    chk("t5.addr",        sd_if.addr, 2);
    chk("t5.err_cnt",     err_cnt_o, 0);
    chk("t5.fail_addr",   fail_addr_o, 0);
    chk("t5.hang_cycles", hang_cycles, TOUT);
    chk("t5.n_reads",     rd_a.size(), 2);
    hang_en = 1'b0;

    // 6: restart at address 7 with coincident ack and rdy
    d = $urandom;
    prep(2'd0, d);
    corrupt[3] = 32'h8000_0000;
    start_sweep(2'd0, d);
    k = 0;
    while (!(sd_if.rd && sd_if.addr == 4'd7) && k < 300) begin
      step();
      k++;
    end
    chk("t6.reached_addr7", {sd_if.rd, sd_if.addr}, {1'b1, 4'd7});
    chk("t6.bad_before", bad_o, 1'b1);
    resp_en = 1'b0;
    ovr_en  = 1'b1; ovr_ack = 1'b1; ovr_rdy = 1'b1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    ovr_en  = 1'b0; ovr_ack = 1'b0; ovr_rdy = 1'b0;
    clear_logs();
    resp_en = 1'b1;
    chk("t6.restart_addr", sd_if.addr, 0);
    chk("t6.restart_rd",   {sd_if.rd, sd_if.wr}, 2'b10);
    chk("t6.restart_stat", {bad_o, timeout_o, done_o, busy_o, err_cnt_o}, {4'b0001, 2'd0});
    step();
    chk("t6.no_advance", sd_if.addr, 0);
    wait_done("t6", 600);
    check_sweep("t6", 2'd0, d);
    corrupt[3] = '0;

    // Randomized sweeps: mode, reference, delays and read corruption
    rand_dly = 1'b1;
    for (int it = 0; it < 6; it++) begin
      m = 2'($urandom_range(0, 3));
      d = $urandom;
      prep(m, d);
      for (int a = 0; a < N; a++)
        corrupt[a] = ($urandom_range(0, 3) == 0) ? (RW'($urandom) | 32'h1) : '0;
      start_sweep(m, d);
      wait_done($sformatf("rnd%0d", it), 800);
      check_sweep($sformatf("rnd%0d", it), m, d);
    end
    for (int a = 0; a < N; a++) corrupt[a] = '0;

    // Reset in the middle of a write sweep
    d = $urandom;
    start_sweep(2'd3, d);
    for (int i = 0; i < 20; i++) step();
    chk("mrst.busy_before", busy_o, 1'b1);
    resp_en = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("mrst.req", {sd_if.rd, sd_if.wr}, 2'b00);
    chk("mrst.stat", {busy_o, bad_o, timeout_o, done_o, sd_if.addr}, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("mrst.idle", {busy_o, done_o, sd_if.rd, sd_if.wr}, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
